// File: rtl/led_select_controller_pkg.sv
// Shared encodings for the LED select controller: run-mode codes, FSM states
// and the mode rotation order.
package led_select_controller_pkg;

  localparam int DEFAULT_NUM_LFSR_BITS = 22;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;

  // Run states share their encoding with the mode codes they represent.
  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_CHASE  = 2'd1,
    ST_RANDOM = 2'd2,
    ST_RESEED = 2'd3
  } state_t;

  function automatic logic [1:0] next_run_mode(input logic [1:0] mode);
    logic [1:0] result;
    case (mode)
      MODE_MANUAL: result = MODE_CHASE;
      MODE_CHASE:  result = MODE_RANDOM;
      default:     result = MODE_MANUAL;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/led_select_controller.sv
// Sequencing controller for the LFSR-driven LED demux: owns LFSR enable/seed
// strobes and produces the demux select and data bit in three run modes.
module led_select_controller
  import led_select_controller_pkg::*;
#(
  parameter int NUM_LFSR_BITS = DEFAULT_NUM_LFSR_BITS,
  parameter logic [NUM_LFSR_BITS-1:0] SEED = {{(NUM_LFSR_BITS-1){1'b0}}, 1'b1}
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Tick,
  input  logic [NUM_LFSR_BITS-1:0] i_LFSR_Data,
  input  logic                     i_Mode_Pulse,
  input  logic [1:0]               i_Manual_Sel,
  output logic                     o_LFSR_Enable,
  output logic                     o_Seed_DV,
  output logic [NUM_LFSR_BITS-1:0] o_Seed_Data,
  output logic [1:0]               o_Sel,
  output logic                     o_Data,
  output logic [1:0]               o_Mode
);

  state_t     state_r, state_s;
  logic [1:0] next_mode_r, next_mode_s;
  logic [1:0] mode_r, mode_s;
  logic [1:0] sel_r, sel_s;
  logic       data_r, data_s;
  logic       enable_r, enable_s;
  logic       seed_dv_r, seed_dv_s;
  logic       lfsr_unused_s;

  // Only the two LSBs of the LFSR pick a random LED.
  assign lfsr_unused_s = ^i_LFSR_Data[NUM_LFSR_BITS-1:2];

  function automatic logic [1:0] next_sel(input state_t st, input logic [1:0] sel,
                                          input logic [1:0] candidate);
    logic [1:0] result;
    case (st)
      ST_CHASE:  result = sel + 2'd1;
      ST_RANDOM: result = (candidate == sel) ? (sel + 2'd1) : candidate;
      default:   result = sel;
    endcase
    return result;
  endfunction

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_s     = state_r;
    next_mode_s = next_mode_r;
    mode_s      = mode_r;
    sel_s       = sel_r;
    data_s      = data_r;
    enable_s    = enable_r;
    seed_dv_s   = 1'b0;
    case (state_r)
      ST_RESEED: begin
        // Arriving from reset the strobe has not been issued yet: issue it first.
        if (!seed_dv_r) begin
          seed_dv_s = 1'b1;
          enable_s  = 1'b0;
        end else begin
          enable_s = 1'b1;
          mode_s   = next_mode_r;
          case (next_mode_r)
            MODE_CHASE: begin
              state_s = ST_CHASE;
              sel_s   = 2'd0;
              data_s  = 1'b1;
            end
            MODE_RANDOM: begin
              state_s = ST_RANDOM;
              data_s  = 1'b1;
            end
            default: begin
              state_s = ST_MANUAL;
              sel_s   = i_Manual_Sel;
              data_s  = 1'b0;
            end
          endcase
        end
      end
      ST_MANUAL, ST_CHASE, ST_RANDOM: begin
        if (i_Mode_Pulse) begin
          next_mode_s = next_run_mode(mode_r);
          state_s     = ST_RESEED;
          seed_dv_s   = 1'b1;
          enable_s    = 1'b0;
        end else if (state_r == ST_MANUAL) begin
          enable_s = 1'b1;
          sel_s    = i_Manual_Sel;
          data_s   = i_Tick ? ~data_r : data_r;
        end else begin
          enable_s = 1'b1;
          data_s   = 1'b1;
          sel_s    = i_Tick ? next_sel(state_r, sel_r, i_LFSR_Data[1:0]) : sel_r;
        end
      end
      default: begin
        state_s = ST_RESEED;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r     <= ST_RESEED;
      next_mode_r <= MODE_MANUAL;
      mode_r      <= MODE_MANUAL;
      sel_r       <= 2'd0;
      data_r      <= 1'b0;
      enable_r    <= 1'b0;
      seed_dv_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      next_mode_r <= next_mode_s;
      mode_r      <= mode_s;
      sel_r       <= sel_s;
      data_r      <= data_s;
      enable_r    <= enable_s;
      seed_dv_r   <= seed_dv_s;
    end
  end

  assign o_LFSR_Enable = enable_r;
  assign o_Seed_DV     = seed_dv_r;
  assign o_Seed_Data   = SEED;
  assign o_Sel         = sel_r;
  assign o_Data        = data_r;
  assign o_Mode        = mode_r;

endmodule

// File: tb/tb_led_select_controller.sv
// Directed, table-driven bench for led_select_controller.
module tb_led_select_controller;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Tick;
  logic [21:0] i_LFSR_Data;
  logic        i_Mode_Pulse;
  logic [1:0]  i_Manual_Sel;
  logic        o_LFSR_Enable;
  logic        o_Seed_DV;
  logic [21:0] o_Seed_Data;
  logic [1:0]  o_Sel;
  logic        o_Data;
  logic [1:0]  o_Mode;

  int tests  = 0;
  int failed = 0;
  logic prev_seed = 1'b0;

  always #5 i_Clk = ~i_Clk;

  led_select_controller dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Tick       (i_Tick),
    .i_LFSR_Data  (i_LFSR_Data),
    .i_Mode_Pulse (i_Mode_Pulse),
    .i_Manual_Sel (i_Manual_Sel),
    .o_LFSR_Enable(o_LFSR_Enable),
    .o_Seed_DV    (o_Seed_DV),
    .o_Seed_Data  (o_Seed_Data),
    .o_Sel        (o_Sel),
    .o_Data       (o_Data),
    .o_Mode       (o_Mode)
  );

  // Expected output word: {seed_dv, enable, mode[1:0], sel[1:0], data}
  typedef struct {
    logic        tick;
    logic        pulse;
    logic [1:0]  man;
    logic [21:0] lfsr;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[33];

  task automatic step(input logic rst, input logic tick, input logic pulse,
                      input logic [1:0] man, input logic [21:0] lfsr,
                      input logic [6:0] exp, input string name);
    logic [6:0] act;
    @(negedge i_Clk);
    i_Reset      = rst;
    i_Tick       = tick;
    i_Mode_Pulse = pulse;
    i_Manual_Sel = man;
    i_LFSR_Data  = lfsr;
    @(posedge i_Clk);
    #1;
    act = {o_Seed_DV, o_LFSR_Enable, o_Mode, o_Sel, o_Data};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got {seed,en,mode,sel,data}=%b want %b", name, act, exp);
    end
    tests++;
    if (o_Seed_Data !== 22'h000001) begin
      failed++;
      $display("FAIL %s seed_data: got %h want 000001", name, o_Seed_Data);
    end
    tests++;
    if ((o_Seed_DV && o_LFSR_Enable) || (o_Seed_DV && prev_seed)) begin
      failed++;
      $display("FAIL %s strobe_rule: seed_dv=%b enable=%b prev_seed=%b want no overlap/repeat",
               name, o_Seed_DV, o_LFSR_Enable, prev_seed);
    end
    prev_seed = o_Seed_DV;
  endtask

  initial begin
    i_Reset      = 1'b1;
    i_Tick       = 1'b0;
    i_Mode_Pulse = 1'b0;
    i_Manual_Sel = 2'd0;
    i_LFSR_Data  = 22'd0;

    //            tick  pulse man    lfsr          exp {seed,en,mode,sel,data}
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 22'h000000, 7'b1000000};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 22'h000000, 7'b0100000};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 22'h000000, 7'b0100100};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0100101};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 22'h000000, 7'b0100101};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0100100};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0100101};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 22'h000000, 7'b1000101};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 22'h000000, 7'b0101001};
    vecs[9]  = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0101011};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0101101};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0101111};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0101001};
    vecs[13] = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0101011};
    vecs[14] = '{1'b0, 1'b1, 2'd2, 22'h000000, 7'b1001011};
    vecs[15] = '{1'b1, 1'b0, 2'd2, 22'h000000, 7'b0110011};
    vecs[16] = '{1'b1, 1'b0, 2'd2, 22'h2AAAA9, 7'b0110101};
    vecs[17] = '{1'b1, 1'b0, 2'd2, 22'h15555B, 7'b0110111};
    vecs[18] = '{1'b0, 1'b0, 2'd2, 22'h15555B, 7'b0110111};
    vecs[19] = '{1'b0, 1'b1, 2'd1, 22'h000000, 7'b1010111};
    vecs[20] = '{1'b0, 1'b0, 2'd1, 22'h000000, 7'b0100010};
    vecs[21] = '{1'b0, 1'b1, 2'd1, 22'h000000, 7'b1000010};
    vecs[22] = '{1'b0, 1'b0, 2'd1, 22'h000000, 7'b0101001};
    vecs[23] = '{1'b1, 1'b0, 2'd1, 22'h000000, 7'b0101011};
    vecs[24] = '{1'b1, 1'b0, 2'd1, 22'h000000, 7'b0101101};
    vecs[25] = '{1'b1, 1'b1, 2'd1, 22'h000000, 7'b1001101};
    vecs[26] = '{1'b0, 1'b0, 2'd1, 22'h000000, 7'b0110101};
    vecs[27] = '{1'b1, 1'b0, 2'd1, 22'h3FFFFC, 7'b0110001};
    vecs[28] = '{1'b0, 1'b1, 2'd3, 22'h000000, 7'b1010001};
    vecs[29] = '{1'b0, 1'b0, 2'd3, 22'h000000, 7'b0100110};
    vecs[30] = '{1'b0, 1'b1, 2'd3, 22'h000000, 7'b1000110};
    vecs[31] = '{1'b0, 1'b0, 2'd3, 22'h000000, 7'b0101001};
    vecs[32] = '{1'b0, 1'b1, 2'd3, 22'h000000, 7'b1001001};

    step(1'b1, 1'b0, 1'b0, 2'd0, 22'h000000, 7'b0000000, "reset_a");
    step(1'b1, 1'b1, 1'b1, 2'd3, 22'h3FFFFF, 7'b0000000, "reset_b");

    for (int i = 0; i < 33; i++) begin
      step(1'b0, vecs[i].tick, vecs[i].pulse, vecs[i].man, vecs[i].lfsr,
           vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset lands in the RESEED cycle that was heading for RANDOM.
    step(1'b1, 1'b1, 1'b0, 2'd2, 22'h000000, 7'b0000000, "reset_in_reseed");
    step(1'b0, 1'b1, 1'b1, 2'd2, 22'h000001, 7'b1000000, "post_reset_reseed");
    step(1'b0, 1'b0, 1'b0, 2'd2, 22'h000000, 7'b0100100, "post_reset_manual");
    step(1'b0, 1'b0, 1'b0, 2'd2, 22'h000000, 7'b0100100, "post_reset_hold");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/led_select_controller.md
# led_select_controller

Sequencing controller for the LFSR-driven LED demux path. It owns the 22-bit LFSR's enable and seed-load controls and generates the demux select and data bit. Three operating modes are available: manual switch select, chase rotation and LFSR-random select. It sits between the debounced switch logic, the LFSR and the 1-to-4 LED demux in the top level.

## Interface
- NUM_LFSR_BITS, 22, width of the LFSR data and seed buses
- SEED, 22'h000001, value loaded into the LFSR on every reseed; must be nonzero

- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Tick  in  1  single-cycle pulse from the LFSR done output
- i_LFSR_Data  in  NUM_LFSR_BITS  current LFSR state
- i_Mode_Pulse  in  1  single-cycle pulse (debounced switch press) that advances the mode
- i_Manual_Sel  in  2  LED select used in MANUAL mode (switch bits)
- o_LFSR_Enable  out  1  LFSR enable
- o_Seed_DV  out  1  LFSR seed-load strobe
- o_Seed_Data  out  NUM_LFSR_BITS  seed value, constant SEED
- o_Sel  out  2  demux select
- o_Data  out  1  demux data, which drives the selected LED
- o_Mode  out  2  current mode: 0 MANUAL, 1 CHASE, 2 RANDOM

## Operation
- FSM states: RESEED, MANUAL, CHASE, RANDOM. A next-mode register records where RESEED exits to.
- Reset (registered outputs, no combinational paths from inputs):
  - all outputs 0; o_Seed_Data = SEED
  - state = RESEED, next-mode = MANUAL
- RESEED lasts exactly one cycle:
  - o_Seed_DV = 1, o_LFSR_Enable = 0
  - i_Tick and i_Mode_Pulse are ignored
  - exits to next-mode
- Every run mode drives o_LFSR_Enable = 1 and o_Seed_DV = 0.
- MANUAL:
  - o_Sel <= i_Manual_Sel every cycle
  - o_Data toggles on each i_Tick
  - on entry, o_Data = 0
- CHASE:
  - o_Data = 1
  - on entry, o_Sel = 0
  - each i_Tick, o_Sel increments, wrapping 3 -> 0
- RANDOM:
  - o_Data = 1
  - on entry, o_Sel keeps its value
  - each i_Tick, candidate = i_LFSR_Data[1:0]
    - if candidate equals the current o_Sel, o_Sel <= o_Sel + 1 (mod 4), so the LED always moves
    - otherwise o_Sel <= candidate
- i_Mode_Pulse in any run mode:
  - next-mode <= mode + 1 in the order MANUAL -> CHASE -> RANDOM -> MANUAL
  - state <= RESEED
  - o_Mode holds the old mode through RESEED
- Simultaneous i_Tick and i_Mode_Pulse: the mode pulse wins and the tick is dropped, so o_Sel and o_Data do not update that cycle.
- i_Reset asserted mid-operation: returns to the reset values on the next edge regardless of state, then performs a fresh RESEED into MANUAL.

## Timing
- Reset release at edge R:
  - o_Seed_DV = 1 during cycle R+1 only
  - at R+2: o_LFSR_Enable = 1, o_Mode = MANUAL
- i_Mode_Pulse sampled at edge N:
  - o_LFSR_Enable = 0 and o_Seed_DV = 1 after N
  - new o_Mode, o_Sel, o_Data and o_LFSR_Enable = 1 after N+1
- i_Tick sampled at edge T updates o_Sel/o_Data after T: one-cycle latency.
- i_Manual_Sel change has one-cycle latency to o_Sel in MANUAL.
- o_Seed_DV is never high for more than one consecutive cycle. o_Seed_DV and o_LFSR_Enable are never high together.

## Structure
- Shared package/include:
  - mode encodings MODE_MANUAL=2'd0, MODE_CHASE=2'd1, MODE_RANDOM=2'd2
  - state encodings, with RESEED=2'd3
  - NUM_LFSR_BITS default
- No sub-module; the next-select logic for CHASE/RANDOM is a local function within the FSM.
- The top level instantiates this block between the switch debouncers and the LFSR/demux, replacing the local toggle register.

## Test plan
- Reset then release:
  - o_Seed_DV is a single-cycle pulse at R+1 with o_LFSR_Enable = 0
  - at R+2, o_Mode = 0 and o_LFSR_Enable = 1
- MANUAL, i_Manual_Sel = 2, three i_Tick pulses:
  - o_Sel = 2 one cycle after the select change
  - o_Data goes 1, 0, 1, each one cycle after its tick
- One mode pulse into CHASE, then five ticks:
  - o_Sel = 0 on entry
  - o_Sel sequence 1, 2, 3, 0, 1 with o_Data held at 1
- RANDOM with o_Sel = 1:
  - tick with i_LFSR_Data[1:0] = 1 -> o_Sel = 2
  - tick with i_LFSR_Data[1:0] = 3 -> o_Sel = 3
- i_Tick and i_Mode_Pulse in the same cycle in CHASE, o_Sel = 2:
  - o_Sel stays 2
  - RESEED follows
  - o_Mode = 2 two cycles later
- i_Reset asserted during RESEED:
  - all outputs 0 next cycle
  - after release, the sequence is RESEED then MANUAL, and next-mode does not resume RANDOM
